// File: rtl/oam_dma.sv
// OAM DMA engine and CPU bus gate.
// A write to 0xFF46 copies 160 bytes from {src,8'h00} into OAM, one byte per
// M-cycle. While the copy runs the CPU only reaches HRAM and 0xFF46; all other
// CPU reads return 0xFF and CPU writes are dropped.
//
// Handshake: there is no valid/ready flow control. A CPU access is a request
// held for a whole M-cycle; reads are answered combinationally and writes take
// effect on the clk edge that ends t_cycle==3. oam_write is a single-clk strobe
// in the t_cycle==3 phase, qualified only by itself.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [6:0]  hram_addr,
  output logic        hram_enable,
  output logic        hram_write,
  output logic [7:0]  hram_wdata,
  input  logic [7:0]  hram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'd159;

  state_t     state, state_next;
  logic [7:0] src, src_next;
  logic [7:0] count, count_next;
  logic       locked, locked_next;

  logic       m_end;
  logic       reg_hit;
  logic       hram_hit;
  logic       bus_hit;
  logic       reg_wr;
  logic [7:0] src_eff;

  // Address decode and the end-of-M-cycle update strobe.
  always_comb begin
    m_end    = (t_cycle == 2'd3);
    reg_hit  = (cpu_addr == 16'hFF46);
    hram_hit = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    bus_hit  = !reg_hit && !hram_hit;
    reg_wr   = cpu_enable && cpu_write && reg_hit;
    // 0xE0-0xFF sources mirror the 0xC0-0xDF work RAM pages.
    src_eff  = (src >= 8'hE0) ? (src & 8'hDF) : src;
  end

  // State register: everything updates only on the last phase of an M-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      src    <= 8'h00;
      count  <= 8'h00;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      src    <= src_next;
      count  <= count_next;
      locked <= locked_next;
    end
  end

  // Next-state logic; an FF46 write restarts from any state and leaves
  // locked untouched so a restart stays locked through its Start cycle.
  always_comb begin
    state_next  = state;
    src_next    = src;
    count_next  = count;
    locked_next = locked;
    if (m_end) begin
      if (reg_wr) begin
        src_next   = cpu_wdata;
        count_next = 8'h00;
        state_next = START;
      end else begin
        case (state)
          START: begin
            state_next  = XFER;
            locked_next = 1'b1;
          end
          XFER: begin
            if (count == LAST_BYTE) begin
              state_next  = IDLE;
              locked_next = 1'b0;
            end else begin
              count_next = count + 8'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Bus, HRAM, OAM and CPU read-data routing, purely from state and CPU inputs.
  always_comb begin
    bus_addr    = cpu_addr;
    bus_enable  = 1'b0;
    bus_write   = 1'b0;
    bus_wdata   = cpu_wdata;
    hram_addr   = cpu_addr[6:0];
    hram_enable = cpu_enable && hram_hit;
    hram_write  = cpu_write && hram_hit;
    hram_wdata  = cpu_wdata;
    oam_write   = 1'b0;
    oam_addr    = 8'h00;
    oam_wdata   = 8'h00;
    cpu_rdata   = 8'hFF;
    dma_active  = locked;

    if (state == XFER) begin
      bus_addr   = {src_eff, count};
      bus_enable = 1'b1;
      if (m_end) begin
        oam_write = 1'b1;
        oam_addr  = count;
        oam_wdata = bus_rdata;
      end
    end else if (!locked && bus_hit) begin
      bus_enable = cpu_enable;
      bus_write  = cpu_write;
    end

    if (cpu_enable) begin
      if (reg_hit) begin
        cpu_rdata = src;
      end else if (hram_hit) begin
        cpu_rdata = hram_rdata;
      end else if (!locked) begin
        cpu_rdata = bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory/HRAM models, table of idle routing vectors,
// directed DMA sequences and randomized CPU traffic against a cycle model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  t_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [6:0]  hram_addr;
  logic        hram_enable;
  logic        hram_write;
  logic [7:0]  hram_wdata;
  logic [7:0]  hram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  oam_dma dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle),
    .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .hram_addr(hram_addr), .hram_enable(hram_enable), .hram_write(hram_write),
    .hram_wdata(hram_wdata), .hram_rdata(hram_rdata),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory models.
  logic [7:0] mem [0:65535];
  logic [7:0] hram [0:127];
  assign bus_rdata  = mem[bus_addr];
  assign hram_rdata = hram[hram_addr];

  always @(posedge clk) begin
    if (t_cycle == 2'd3 && bus_enable && bus_write) mem[bus_addr] <= bus_wdata;
    if (t_cycle == 2'd3 && hram_enable && hram_write) hram[hram_addr] <= hram_wdata;
  end

  // Scoreboard.
  int vectors = 0;
  int miscompares = 0;
  int mcyc = 0;
  int oam_cnt = 0;
  int act_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (mcyc %0d)", name, got, exp, mcyc);
    end
  endtask

  // OAM write monitor: each strobe must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (oam_write === 1'b1) begin
      oam_cnt++;
      chk("oam_phase", {14'd0, t_cycle}, 16'd3);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL oam_extra: got write addr %h data %h expected none", oam_addr, oam_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("oam_byte", {oam_addr, oam_wdata}, e);
      end
    end
  end

  // Reference model helpers.
  function automatic logic [7:0] src_map(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  function automatic bit is_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  task automatic push_dma(input logic [7:0] s);
    for (int i = 0; i < 160; i++)
      exp_q.push_back({8'(i), mem[{src_map(s), 8'(i)}]});
  endtask

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
    t_cycle = t_cycle + 2'd1;
    if (t_cycle == 2'd0) mcyc++;
  endtask

  task automatic next_m();
    do tick(); while (t_cycle != 2'd0);
  endtask

  task automatic drive(input logic [15:0] a, input logic en, input logic wr, input logic [7:0] d);
    cpu_addr = a; cpu_enable = en; cpu_write = wr; cpu_wdata = d;
  endtask

  task automatic write_ff46(input logic [7:0] v);
    drive(16'hFF46, 1'b1, 1'b1, v);
    next_m();
    drive(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  // One M-cycle of CPU access; n is the M-cycle of the last FF46 write,
  // s the current source, ls whether that write was a restart.
  task automatic mstep(input int n, input logic [7:0] s, input bit ls,
                       input logic [15:0] a, input logic wr, input logic [7:0] d);
    int k;
    bit xfer, act, hit, busr;
    logic [7:0] exp_rd;
    k    = mcyc - n;
    xfer = (k >= 2) && (k <= 161);
    act  = xfer || (k == 1 && ls);
    hit  = is_hram(a);
    busr = !hit && (a != 16'hFF46);
    drive(a, 1'b1, wr, d);
    @(negedge clk);
    chk("dma_active", {15'd0, dma_active}, {15'd0, act});
    if (dma_active) act_cnt++;
    if (xfer) begin
      chk("dma_bus_addr", bus_addr, {src_map(s), 8'(k - 2)});
      chk("dma_bus_en", {15'd0, bus_enable}, 16'd1);
      chk("dma_bus_wr", {15'd0, bus_write}, 16'd0);
    end else if (act) begin
      chk("start_bus_en", {15'd0, bus_enable}, 16'd0);
      chk("start_bus_wr", {15'd0, bus_write}, 16'd0);
    end else if (busr) begin
      chk("pass_addr", bus_addr, a);
      chk("pass_en", {15'd0, bus_enable}, 16'd1);
      chk("pass_wr", {15'd0, bus_write}, {15'd0, wr});
    end
    chk("hram_en", {15'd0, hram_enable}, {15'd0, hit});
    chk("hram_wr", {15'd0, hram_write}, {15'd0, wr && hit});
    if (!wr) begin
      if (a == 16'hFF46) exp_rd = s;
      else if (hit) exp_rd = hram[a[6:0]];
      else if (act) exp_rd = 8'hFF;
      else exp_rd = mem[a];
      chk("cpu_rdata", {8'd0, cpu_rdata}, {8'd0, exp_rd});
    end
    next_m();
  endtask

  task automatic rand_step(input int n, input logic [7:0] s, input bit ls);
    int kind;
    kind = $urandom_range(0, 4);
    case (kind)
      0: mstep(n, s, ls, 16'h4000 + 16'($urandom_range(0, 16'h3FFF)), 1'b0, 8'h00);
      1: mstep(n, s, ls, 16'hFF46, 1'b0, 8'h00);
      2: mstep(n, s, ls, 16'hFF80 + 16'($urandom_range(0, 126)), 1'b0, 8'h00);
      3: mstep(n, s, ls, 16'hFF80 + 16'($urandom_range(0, 126)), 1'b1, 8'($urandom));
      default: mstep(n, s, ls, 16'($urandom_range(0, 16'h3FFF)), 1'b1, 8'($urandom));
    endcase
  endtask

  task automatic fill_src(input logic [7:0] s);
    for (int i = 0; i < 160; i++) mem[{src_map(s), 8'(i)}] = 8'($urandom);
  endtask

  // Fresh DMA from idle with random CPU traffic, then completeness checks.
  task automatic run_fresh(input logic [7:0] s);
    int n, o0;
    fill_src(s);
    n = mcyc;
    o0 = oam_cnt;
    act_cnt = 0;
    write_ff46(s);
    push_dma(s);
    for (int k = 1; k <= 165; k++) rand_step(n, s, 1'b0);
    chk("rnd_oam_count", 16'(oam_cnt - o0), 16'd160);
    chk("rnd_active_cycles", 16'(act_cnt), 16'd160);
    chk("rnd_queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        en;
    logic        exp_bus_en;
    logic        exp_hram_en;
    logic        exp_hram_wr;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl [11];

  // Watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  // Main test.
  initial begin
    int n, o0, mark;
    tbl[0]  = '{16'h4000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[1]  = '{16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[2]  = '{16'hFF7F, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5D};
    tbl[3]  = '{16'hFF45, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3};
    tbl[4]  = '{16'hFF80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[5]  = '{16'hFF90, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77};
    tbl[6]  = '{16'hFFFE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE7};
    tbl[7]  = '{16'hFF46, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{16'h4000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    tbl[9]  = '{16'h8000, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{16'hFFA0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) hram[i] = 8'($urandom);
    mem[16'h4000] = 8'hA5; mem[16'hFFFF] = 8'h3C; mem[16'hFF7F] = 8'h5D;
    mem[16'hFF45] = 8'hC3; mem[16'hD000] = 8'h99;
    hram[0] = 8'h11; hram[7'h10] = 8'h77; hram[7'h7E] = 8'hE7;

    // Reset.
    reset = 1'b1;
    t_cycle = 2'd0;
    drive(16'h0000, 1'b0, 1'b0, 8'h00);
    repeat (8) tick();
    @(negedge clk);
    chk("rst_dma_active", {15'd0, dma_active}, 16'd0);
    chk("rst_oam_write", {15'd0, oam_write}, 16'd0);
    chk("rst_oam_addr", {8'd0, oam_addr}, 16'd0);
    chk("rst_oam_wdata", {8'd0, oam_wdata}, 16'd0);
    reset = 1'b0;
    next_m();

    // Idle routing table.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].addr, tbl[i].en, tbl[i].wr, tbl[i].wdata);
      @(negedge clk);
      chk("tbl_bus_en", {15'd0, bus_enable}, {15'd0, tbl[i].exp_bus_en});
      if (tbl[i].exp_bus_en) begin
        chk("tbl_bus_addr", bus_addr, tbl[i].addr);
        chk("tbl_bus_wr", {15'd0, bus_write}, {15'd0, tbl[i].wr});
      end
      chk("tbl_hram_en", {15'd0, hram_enable}, {15'd0, tbl[i].exp_hram_en});
      chk("tbl_hram_wr", {15'd0, hram_write}, {15'd0, tbl[i].exp_hram_wr});
      chk("tbl_dma_active", {15'd0, dma_active}, 16'd0);
      if (tbl[i].chk_rd) chk("tbl_cpu_rdata", {8'd0, cpu_rdata}, {8'd0, tbl[i].exp_rd});
      next_m();
    end
    drive(16'h0000, 1'b0, 1'b0, 8'h00);

    // DMA from 0xC100 with directed CPU accesses while locked.
    for (int i = 0; i < 160; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
    n = mcyc;
    o0 = oam_cnt;
    act_cnt = 0;
    write_ff46(8'hC1);
    push_dma(8'hC1);
    for (int k = 1; k <= 165; k++) begin
      case (k)
        20: mstep(n, 8'hC1, 1'b0, 16'hFF90, 1'b1, 8'h34);
        21: begin
          mstep(n, 8'hC1, 1'b0, 16'hFF90, 1'b0, 8'h00);
          chk("hram_written_34", {8'd0, hram[7'h10]}, 16'h0034);
        end
        22: mstep(n, 8'hC1, 1'b0, 16'hC000, 1'b0, 8'h00);
        23: mstep(n, 8'hC1, 1'b0, 16'hD000, 1'b1, 8'h12);
        default: rand_step(n, 8'hC1, 1'b0);
      endcase
    end
    chk("c1_oam_count", 16'(oam_cnt - o0), 16'd160);
    chk("c1_active_cycles", 16'(act_cnt), 16'd160);
    chk("c1_queue_empty", 16'(exp_q.size()), 16'd0);
    chk("c1_d000_kept", {8'd0, mem[16'hD000]}, 16'h0099);

    // Mirrored source 0xFE -> 0xDE00.
    fill_src(8'hFE);
    n = mcyc;
    write_ff46(8'hFE);
    push_dma(8'hFE);
    for (int k = 1; k <= 165; k++) begin
      if (k == 5) mstep(n, 8'hFE, 1'b0, 16'hFF46, 1'b0, 8'h00);
      else rand_step(n, 8'hFE, 1'b0);
    end
    chk("fe_queue_empty", 16'(exp_q.size()), 16'd0);

    // Restart at byte 80 with source 0x80.
    fill_src(8'hC1);
    fill_src(8'h80);
    n = mcyc;
    o0 = oam_cnt;
    act_cnt = 0;
    write_ff46(8'hC1);
    push_dma(8'hC1);
    for (int k = 1; k <= 81; k++) rand_step(n, 8'hC1, 1'b0);
    n = mcyc;
    write_ff46(8'h80);
    exp_q.delete();
    push_dma(8'h80);
    for (int k = 1; k <= 165; k++) rand_step(n, 8'h80, 1'b1);
    chk("rs_oam_count", 16'(oam_cnt - o0), 16'd241);
    chk("rs_active_cycles", 16'(act_cnt), 16'd241);
    chk("rs_queue_empty", 16'(exp_q.size()), 16'd0);

    // Randomized sources.
    repeat (3) begin
      logic [7:0] s;
      s = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'hC0, 8'hFF))
                                      : 8'($urandom_range(8'h80, 8'h9F));
      run_fresh(s);
    end

    // Reset at byte 50.
    fill_src(8'hC1);
    n = mcyc;
    write_ff46(8'hC1);
    push_dma(8'hC1);
    for (int k = 1; k <= 51; k++) rand_step(n, 8'hC1, 1'b0);
    exp_q.delete();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_dma_active", {15'd0, dma_active}, 16'd0);
    chk("midrst_oam_write", {15'd0, oam_write}, 16'd0);
    while (t_cycle != 2'd0) tick();
    reset = 1'b0;
    mark = oam_cnt;
    mstep(mcyc - 1000, 8'h00, 1'b0, 16'hFF46, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) rand_step(mcyc - 1000, 8'h00, 1'b0);
    chk("no_oam_after_reset", 16'(oam_cnt - mark), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine and CPU bus gate, sitting directly downstream of the `cpu` memory port and upstream of the system bus, HRAM and OAM. It owns the DMA register at 0xFF46. A write to that register copies 160 bytes from `{src, 8'h00}` into OAM at one byte per M-cycle. While the copy runs, CPU accesses outside HRAM and 0xFF46 are blocked.

## Interface
No parameters.
- `clk`  in  1  clock, 4 clk per M-cycle
- `reset`  in  1  reset, synchronous, active-high
- `t_cycle`  in  2  M-cycle phase shared with `cpu`; all state updates at `t_cycle==3`
- `cpu_addr`  in  16  CPU bus address
- `cpu_enable`  in  1  CPU access request
- `cpu_write`  in  1  CPU write strobe
- `cpu_wdata`  in  8  CPU write data
- `cpu_rdata`  out  8  read data returned to CPU
- `bus_addr`  out  16  system bus address
- `bus_enable`  out  1  system bus access enable
- `bus_write`  out  1  system bus write enable
- `bus_wdata`  out  8  system bus write data
- `bus_rdata`  in  8  system bus read data
- `hram_addr`  out  7  HRAM index (`cpu_addr[6:0]`)
- `hram_enable`  out  1  HRAM access enable
- `hram_write`  out  1  HRAM write enable
- `hram_wdata`  out  8  HRAM write data
- `hram_rdata`  in  8  HRAM read data
- `oam_addr`  out  8  OAM byte index 0..159
- `oam_write`  out  1  OAM write strobe, one clk wide
- `oam_wdata`  out  8  OAM write data
- `dma_active`  out  1  CPU bus is locked out

## Operation
- State
  - `src` (8b, reset 0x00)
  - `count` (8b, reset 0)
  - `fsm` ∈ {Idle, Start, Xfer}, reset Idle
  - `locked` (1b, reset 0)
- Address decode on `cpu_addr`
  - 0xFF80–0xFFFE → HRAM port, at all times.
  - 0xFF46 → local register, at all times. Never forwarded to bus or HRAM.
  - Everything else (including 0xFFFF) → system bus.
- Local register access
  - Write: `cpu_enable & cpu_write & addr==FF46` at `t_cycle==3` sets `src<=cpu_wdata`, `count<=0`, `fsm<=Start`.
  - Read returns `src`.
- FSM transitions, evaluated at `t_cycle==3`
  - Idle: wait for an FF46 write.
  - Start: one M-cycle of setup with no transfer; next state Xfer.
  - Xfer: for the whole M-cycle, `bus_addr={src_eff,count}`, `bus_enable=1`, `bus_write=0`.
    - At `t_cycle==3`: `oam_write=1`, `oam_addr=count`, `oam_wdata=bus_rdata`, then `count<=count+1`.
    - After `count==159` is written, go to Idle.
- Source mapping: `src_eff = (src>=0xE0) ? (src & 0xDF) : src`, so 0xE0–0xFF mirror 0xC0–0xDF.
- `locked` (drives `dma_active`)
  - Set when entering Xfer.
  - Cleared when Xfer→Idle.
  - A restart (FF46 write while `locked`) keeps `locked=1` through the new Start cycle.
  - A fresh start from Idle leaves the bus unlocked during Start.
- CPU routing while `locked=0`
  - System-bus region passes straight through: `bus_* = cpu_*`, `cpu_rdata = bus_rdata`.
  - While `fsm==Start` and `locked=0`, `bus_enable=cpu_enable` (CPU owns the bus).
- CPU routing while `locked=1`, system-bus region only
  - CPU reads return 0xFF.
  - CPU writes are dropped.
  - The bus carries DMA traffic when in Xfer; when in Start, `bus_enable=0`.
- HRAM port: `hram_enable = cpu_enable & hit`, `hram_write = cpu_write & hit`, `cpu_rdata = hram_rdata` on a hit.
- `cpu_rdata` default when no access: 0xFF.
- All routing and bus outputs are combinational from current state and CPU inputs. Only `src`, `count`, `fsm` and `locked` are registered.

## Timing
- Reset: `dma_active=0`, `oam_write=0`, `oam_addr=0`, `oam_wdata=0`, `fsm=Idle`, `src=0x00`.
- Reset mid-transfer aborts immediately. The next clk shows `dma_active=0`, and no further `oam_write`.
- FF46 written in M-cycle N:
  - Start occupies N+1.
  - Byte i is transferred in N+2+i.
  - Last byte is transferred in N+161.
  - `dma_active` is high N+2..N+161 and low from N+162.
- Total lockout is 160 M-cycles (161 if the write was a restart, because Start is also locked).
- Restart during Xfer: the current M-cycle's byte is still written. Then Start, then count restarts at 0 from the new `src`.
- `oam_write` pulses exactly once per Xfer M-cycle: 160 pulses per completed transfer.
- `count` never exceeds 159; no wrap.

## Test plan
- Write 0xC1 to FF46 with memory 0xC100+i = i^0x5A:
  - exactly 160 `oam_write` pulses;
  - `oam_wdata[i] = i^0x5A`, `oam_addr` 0..159;
  - `dma_active` high exactly 160 M-cycles, starting 2 M-cycles after the write.
- During DMA, CPU reads 0xC000 → 0xFF, no CPU-driven bus cycle; CPU writes 0x12 to 0xD000 → dropped, `bus_write` stays 0; CPU writes/reads 0xFF90 → HRAM strobes fire, value 0x34 read back.
- Write 0xFE to FF46 → bus addresses 0xDE00..0xDE9F; FF46 reads back 0xFE.
- Restart at byte 80 with src 0x80:
  - `dma_active` stays high continuously;
  - byte 80 from the old source is written, then one locked Start cycle;
  - 160 bytes from 0x8000 follow.
- Assert `reset` at byte 50 → next clk `dma_active=0`, FF46 reads 0x00, no further `oam_write`.
- Idle pass-through: CPU read 0x4000 with `bus_rdata=0xA5` → `cpu_rdata=0xA5`, `bus_addr=0x4000`, `dma_active=0`.
